// File: rtl/dsg_pkg.sv
// Shared constants and helpers for the multi-channel delta-sigma DAC.
package dsg_pkg;

   localparam int unsigned ORD1 = 1;
   localparam int unsigned ORD2 = 2;

   // Ceiling log2, used to size the mixer sum; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/dsg_multi_if.sv
// Sample-side bus of the DAC: strobe, packed samples, mutes and the 1-bit pins.
interface dsg_multi_if #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 2
);

   logic                      ce;
   logic [CHANNELS*WIDTH-1:0] data;
   logic [CHANNELS-1:0]       mute;
   logic [CHANNELS-1:0]       dout;

   modport master (output ce, data, mute, input dout);
   modport slave  (input ce, data, mute, output dout);

endinterface

// File: rtl/dsg_chan.sv
// One delta-sigma modulator channel, 1st or 2nd order, output registered.
module dsg_chan
   import dsg_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ORDER = ORD1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] sample,
   output logic             dout
);

   if (ORDER == ORD1) begin : g_ord1
      logic [WIDTH:0] acc_q;
      logic [WIDTH:0] acc_d;

      // Carry out of the phase accumulator is the bit stream.
      always_comb begin
         acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, sample};
      end

      // Accumulator register; the carry bit doubles as the output register.
      always_ff @(posedge clock) begin
         if (reset) acc_q <= '0;
         else       acc_q <= acc_d;
      end

      assign dout = acc_q[WIDTH];

   end else if (ORDER == ORD2) begin : g_ord2
      localparam int unsigned IW = WIDTH + 4;
      // Working width leaves headroom for two additions before clamping.
      localparam int unsigned XW = WIDTH + 6;
      localparam logic signed [XW-1:0] SAT_HI = XW'((1 << (WIDTH + 2)) - 1);
      localparam logic signed [XW-1:0] SAT_LO = -SAT_HI - 1;
      localparam logic signed [XW-1:0] FB_ONE = XW'(1 << WIDTH);

      logic signed [IW-1:0] i1_q, i1_d;
      logic signed [IW-1:0] i2_q, i2_d;
      logic                 dout_q, dout_d;
      logic signed [XW-1:0] fb, s_ext, i1_sum, i2_sum;

      function automatic logic signed [IW-1:0] sat(input logic signed [XW-1:0] v);
         if (v > SAT_HI)      return SAT_HI[IW-1:0];
         else if (v < SAT_LO) return SAT_LO[IW-1:0];
         else                 return v[IW-1:0];
      endfunction

      // Two cascaded saturating integrators, both fed back from the last output bit.
      always_comb begin
         fb     = dout_q ? FB_ONE : '0;
         s_ext  = {{(XW-WIDTH){1'b0}}, sample};
         i1_sum = {{(XW-IW){i1_q[IW-1]}}, i1_q} + s_ext - fb;
         i1_d   = sat(i1_sum);
         i2_sum = {{(XW-IW){i2_q[IW-1]}}, i2_q} + {{(XW-IW){i1_d[IW-1]}}, i1_d} - fb;
         i2_d   = sat(i2_sum);
         // Strictly positive, so an all-zero (idle or just reset) channel stays silent.
         dout_d = !i2_d[IW-1] && (i2_d != '0);
      end

      // Integrator and output state.
      always_ff @(posedge clock) begin
         if (reset) begin
            i1_q   <= '0;
            i2_q   <= '0;
            dout_q <= 1'b0;
         end else begin
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            dout_q <= dout_d;
         end
      end

      assign dout = dout_q;

   end else begin : g_bad_order
      $error("dsg_chan: ORDER must be 1 or 2");
   end

endmodule

// File: rtl/dsg_multi.sv
// Multi-channel delta-sigma DAC: ce-gated sample latch with mute, optional
// mono mixdown, and one modulator per output pin.
module dsg_multi
   import dsg_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned ORDER    = ORD1,
   parameter int unsigned MIX      = 0
) (
   input logic        clock,
   input logic        reset,
   dsg_multi_if.slave bus
);

   logic [WIDTH-1:0]    s_q     [CHANNELS];
   logic [WIDTH-1:0]    chan_in [CHANNELS];
   logic [CHANNELS-1:0] dout_w;

   // Sample latch: capture (or zero, when muted) on ce, hold otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned n = 0; n < CHANNELS; n++) s_q[n] <= '0;
      end else if (bus.ce) begin
         for (int unsigned n = 0; n < CHANNELS; n++) begin
            s_q[n] <= bus.mute[n] ? '0 : bus.data[n*WIDTH +: WIDTH];
         end
      end
   end

   if (MIX != 0) begin : g_mix
      localparam int unsigned SW = WIDTH + clog2(CHANNELS);

      logic [SW-1:0]    sum;
      logic [WIDTH-1:0] m_d;
      logic [WIDTH-1:0] m_q;

      // Sum of all latched samples; muted channels were already latched as 0.
      always_comb begin
         sum = '0;
         for (int unsigned n = 0; n < CHANNELS; n++) sum = sum + SW'(s_q[n]);
      end

      if ((CHANNELS & (CHANNELS - 1)) == 0) begin : g_shift
         assign m_d = WIDTH'(sum >> clog2(CHANNELS));
      end else begin : g_div
         assign m_d = WIDTH'(sum / SW'(CHANNELS));
      end

      // Registered mix value.
      always_ff @(posedge clock) begin
         if (reset) m_q <= '0;
         else       m_q <= m_d;
      end

      // Every modulator sees the same mix value, so all pins are identical.
      always_comb begin
         for (int unsigned n = 0; n < CHANNELS; n++) chan_in[n] = m_q;
      end

   end else begin : g_direct
      // Channel n drives pin n.
      always_comb begin
         for (int unsigned n = 0; n < CHANNELS; n++) chan_in[n] = s_q[n];
      end
   end

   for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
      dsg_chan #(
         .WIDTH (WIDTH),
         .ORDER (ORDER)
      ) u_chan (
         .clock  (clock),
         .reset  (reset),
         .sample (chan_in[n]),
         .dout   (dout_w[n])
      );
   end

   assign bus.dout = dout_w;

endmodule

// File: tb/tb_dsg_multi.sv
// Directed bench for dsg_multi: three instances cover 1st order direct,
// 1st order mono mix with mute, and 2nd order direct.
module tb_dsg_multi;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   dsg_multi_if #(.WIDTH(8), .CHANNELS(2)) b1 ();
   dsg_multi_if #(.WIDTH(8), .CHANNELS(2)) b2 ();
   dsg_multi_if #(.WIDTH(8), .CHANNELS(2)) b3 ();

   dsg_multi #(.WIDTH(8), .CHANNELS(2), .ORDER(1), .MIX(0)) u1 (
      .clock (clock),
      .reset (reset),
      .bus   (b1)
   );

   dsg_multi #(.WIDTH(8), .CHANNELS(2), .ORDER(1), .MIX(1)) u2 (
      .clock (clock),
      .reset (reset),
      .bus   (b2)
   );

   dsg_multi #(.WIDTH(8), .CHANNELS(2), .ORDER(2), .MIX(0)) u3 (
      .clock (clock),
      .reset (reset),
      .bus   (b3)
   );

   task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
      n_checks++;
      if (obs > exp + tol || obs < exp - tol) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Run for a number of cycles on one bus, counting ones per pin and pin disagreements.
   task automatic run(input int sel, input int cycles, output int c0, output int c1,
                      output int neq);
      logic [1:0] d;
      c0  = 0;
      c1  = 0;
      neq = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         case (sel)
            1:       d = b1.dout;
            2:       d = b2.dout;
            default: d = b3.dout;
         endcase
         c0  += int'(d[0]);
         c1  += int'(d[1]);
         neq += int'(d[0] != d[1]);
      end
   endtask

   task automatic pulse_ce(input int sel);
      case (sel)
         1:       b1.ce = 1'b1;
         2:       b2.ce = 1'b1;
         default: b3.ce = 1'b1;
      endcase
      tick();
      b1.ce = 1'b0;
      b2.ce = 1'b0;
      b3.ce = 1'b0;
   endtask

   initial begin
      int c0, c1, neq, ones;
      int v1, v2, viol1, viol2;

      b1.ce = 1'b0; b1.data = '0; b1.mute = '0;
      b2.ce = 1'b0; b2.data = '0; b2.mute = '0;
      b3.ce = 1'b0; b3.data = '0; b3.mute = '0;

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_dout1", int'(b1.dout), 0);
      check("rst_dout2", int'(b2.dout), 0);
      check("rst_dout3", int'(b3.dout), 0);

      // 1st order, half scale: two cycles of 0 after the latch, then 1,0,1,0
      b1.data = {8'd0, 8'd128};
      pulse_ce(1);
      check("half_lat0", int'(b1.dout[0]), 0);
      tick();
      check("half_lat1", int'(b1.dout[0]), 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("half_alt%0d", i), int'(b1.dout[0]), (i % 2 == 0) ? 1 : 0);
      end
      run(1, 1024, c0, c1, neq);
      check("half_ones", c0, 512);
      check("half_ch1_zero", c1, 0);

      // Zero and full scale
      b1.data = {8'd255, 8'd0};
      pulse_ce(1);
      run(1, 4, c0, c1, neq);
      run(1, 1024, c0, c1, neq);
      check("zero_ones", c0, 0);
      check("full_ones", c1, 1020);

      // ce gating: data changes without ce must be ignored
      b1.data = {8'd0, 8'd64};
      pulse_ce(1);
      run(1, 4, c0, c1, neq);
      b1.data = {8'd0, 8'd200};
      run(1, 1024, c0, c1, neq);
      check("gate_hold", c0, 256);
      pulse_ce(1);
      run(1, 4, c0, c1, neq);
      run(1, 1024, c0, c1, neq);
      check("gate_new", c0, 800, 1);

      // Mono mix with ch0 muted: m = (0 + 100) / 2 = 50
      b2.data = {8'd100, 8'd200};
      b2.mute = 2'b01;
      pulse_ce(2);
      run(2, 4, c0, c1, neq);
      run(2, 2560, c0, c1, neq);
      check("mix_mute_ones", c0, 500, 1);
      check("mix_mute_pins", neq, 0);
      // Unmuted: m = (200 + 100) / 2 = 150
      b2.mute = 2'b00;
      pulse_ce(2);
      run(2, 4, c0, c1, neq);
      run(2, 256, c0, c1, neq);
      check("mix_ones", c0, 150);
      check("mix_ones_pin1", c1, 150);
      check("mix_pins", neq, 0);

      // 2nd order, quarter scale
      b3.data = {8'd0, 8'd64};
      pulse_ce(3);
      run(3, 64, c0, c1, neq);
      run(3, 1024, c0, c1, neq);
      check("o2_quarter", c0, 256, 2);
      check("o2_ch1_zero", c1, 0);

      // 2nd order, near full scale: integrators stay inside the clamp range
      b3.data = {8'd0, 8'd255};
      pulse_ce(3);
      ones  = 0;
      viol1 = 0;
      viol2 = 0;
      for (int i = 0; i < 4096; i++) begin
         tick();
         ones += int'(b3.dout[0]);
         v1 = int'($signed(u3.g_chan[0].u_chan.g_ord2.i1_q));
         v2 = int'($signed(u3.g_chan[0].u_chan.g_ord2.i2_q));
         if (v1 > 1023 || v1 < -1024) viol1++;
         if (v2 > 1023 || v2 < -1024) viol2++;
      end
      check("o2_i1_bounds", viol1, 0);
      check("o2_i2_bounds", viol2, 0);
      check("o2_full_dens", int'(ones >= 4056), 1);

      // One-cycle reset mid-stream clears everything
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_dout", int'(b3.dout), 0);
      check("mrst_i1", int'($signed(u3.g_chan[0].u_chan.g_ord2.i1_q)), 0);
      check("mrst_i2", int'($signed(u3.g_chan[0].u_chan.g_ord2.i2_q)), 0);
      check("mrst_s", int'(u3.s_q[0]), 0);
      run(3, 512, c0, c1, neq);
      check("mrst_quiet0", c0, 0);
      check("mrst_quiet1", c1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
